// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with two combinational read ports,
// one synchronous write port, optional hardwired zero register, optional
// write-to-read bypass and a per-register pending scoreboard for hazard stalls.
module reg_file_sb #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned ZERO_EN    = 1,
    parameter int unsigned ZERO_REG   = 31,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] reg_write_dest,
    input  logic [DATA_WIDTH-1:0] reg_write_data,
    input  logic [ADDR_WIDTH-1:0] reg_read_addr_1,
    input  logic [ADDR_WIDTH-1:0] reg_read_addr_2,
    output logic [DATA_WIDTH-1:0] reg_read_data_1,
    output logic [DATA_WIDTH-1:0] reg_read_data_2,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_dest,
    output logic                  busy_1,
    output logic                  busy_2
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);
    localparam bit                    ZERO_ON   = (ZERO_EN != 0);
    localparam bit                    BYPASS_ON = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   pending_nxt;

    logic wr_en;
    logic clr_en;
    logic issue_en;
    logic fwd_1;
    logic fwd_2;

    // An address is live when it names an implemented, writable register
    function automatic logic addr_live(input logic [ADDR_WIDTH-1:0] addr);
        return (32'(addr) < 32'(NUM_REGS)) && !(ZERO_ON && (addr == ZERO_ADDR));
    endfunction

    // Qualify write, retire and issue requests against the implemented range
    always_comb begin
        wr_en    = reg_write && addr_live(reg_write_dest);
        clr_en   = wr_en;
        issue_en = issue_valid && addr_live(issue_dest);
        fwd_1    = BYPASS_ON && reg_write && (reg_write_dest == reg_read_addr_1);
        fwd_2    = BYPASS_ON && reg_write && (reg_write_dest == reg_read_addr_2);
    end

    // Scoreboard update: retire first, then issue so a new producer wins
    always_comb begin
        pending_nxt = pending;
        if (clr_en) begin
            pending_nxt[reg_write_dest] = 1'b0;
        end
        if (issue_en) begin
            pending_nxt[issue_dest] = 1'b1;
        end
    end

    // Storage and scoreboard state; reset clears everything and drops requests
    always_ff @(posedge clk) begin
        if (!reset) begin
            regs    <= '{default: '0};
            pending <= '0;
        end else begin
            if (wr_en) begin
                regs[reg_write_dest] <= reg_write_data;
            end
            pending <= pending_nxt;
        end
    end

    // Read port 1: zero/out-of-range first, then bypass, then storage
    always_comb begin
        reg_read_data_1 = '0;
        busy_1          = 1'b0;
        if (addr_live(reg_read_addr_1)) begin
            if (fwd_1) begin
                reg_read_data_1 = reg_write_data;
            end else begin
                reg_read_data_1 = regs[reg_read_addr_1];
                busy_1          = pending[reg_read_addr_1];
            end
        end
    end

    // Read port 2: identical priority to port 1
    always_comb begin
        reg_read_data_2 = '0;
        busy_2          = 1'b0;
        if (addr_live(reg_read_addr_2)) begin
            if (fwd_2) begin
                reg_read_data_2 = reg_write_data;
            end else begin
                reg_read_data_2 = regs[reg_read_addr_2];
                busy_2          = pending[reg_read_addr_2];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a bypassing instance and a non-bypassing
// instance share all inputs so forwarding behaviour can be compared directly.
module tb_reg_file_sb;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [4:0]  reg_write_dest;
    logic [63:0] reg_write_data;
    logic [4:0]  reg_read_addr_1;
    logic [4:0]  reg_read_addr_2;
    logic        issue_valid;
    logic [4:0]  issue_dest;

    logic [63:0] rd1, rd2, nb_rd1, nb_rd2;
    logic        busy1, busy2, nb_busy1, nb_busy2;

    int tests_run;
    int tests_failed;

    reg_file_sb #(.BYPASS(1)) dut (
        .clk(clk), .reset(reset),
        .reg_write(reg_write), .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
        .reg_read_addr_1(reg_read_addr_1), .reg_read_addr_2(reg_read_addr_2),
        .reg_read_data_1(rd1), .reg_read_data_2(rd2),
        .issue_valid(issue_valid), .issue_dest(issue_dest),
        .busy_1(busy1), .busy_2(busy2)
    );

    reg_file_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset),
        .reg_write(reg_write), .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
        .reg_read_addr_1(reg_read_addr_1), .reg_read_addr_2(reg_read_addr_2),
        .reg_read_data_1(nb_rd1), .reg_read_data_2(nb_rd2),
        .issue_valid(issue_valid), .issue_dest(issue_dest),
        .busy_1(nb_busy1), .busy_2(nb_busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to mid-cycle where outputs are sampled
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reg_write      = 1'b0;
        reg_write_dest = 5'd0;
        reg_write_data = 64'd0;
        issue_valid    = 1'b0;
        issue_dest     = 5'd0;
    endtask

    task automatic test_reset();
        reset           = 1'b0;
        reg_write       = 1'b1;
        reg_write_dest  = 5'd6;
        reg_write_data  = 64'h1234;
        issue_valid     = 1'b1;
        issue_dest      = 5'd5;
        reg_read_addr_1 = 5'd6;
        reg_read_addr_2 = 5'd5;
        tick();
        reset = 1'b1;
        idle_inputs();
        mid();
        tests_run++;
        if (rd1 !== 64'd0) begin tests_failed++; $display("FAIL reset_rd1: got %h expected %h", rd1, 64'd0); end
        tests_run++;
        if (rd2 !== 64'd0) begin tests_failed++; $display("FAIL reset_rd2: got %h expected %h", rd2, 64'd0); end
        tests_run++;
        if (busy1 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy1: got %b expected 0", busy1); end
        tests_run++;
        if (busy2 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy2: got %b expected 0", busy2); end
        tests_run++;
        if (nb_rd1 !== 64'd0) begin tests_failed++; $display("FAIL reset_nb_rd1: got %h expected %h", nb_rd1, 64'd0); end
        tick();
    endtask

    task automatic test_write_read();
        reg_write       = 1'b1;
        reg_write_dest  = 5'd7;
        reg_write_data  = 64'd916;
        reg_read_addr_1 = 5'd0;
        reg_read_addr_2 = 5'd5;
        tick();
        idle_inputs();
        reg_read_addr_1 = 5'd7;
        mid();
        tests_run++;
        if (rd1 !== 64'h394) begin tests_failed++; $display("FAIL write_read_rd1: got %h expected %h", rd1, 64'h394); end
        tests_run++;
        if (nb_rd1 !== 64'h394) begin tests_failed++; $display("FAIL write_read_nb_rd1: got %h expected %h", nb_rd1, 64'h394); end
        tests_run++;
        if (rd2 !== 64'd0) begin tests_failed++; $display("FAIL write_read_rd2: got %h expected %h", rd2, 64'd0); end
        tick();
    endtask

    task automatic test_bypass();
        reg_write       = 1'b1;
        reg_write_dest  = 5'd3;
        reg_write_data  = 64'hDEAD_BEEF;
        reg_read_addr_1 = 5'd3;
        reg_read_addr_2 = 5'd7;
        mid();
        tests_run++;
        if (rd1 !== 64'hDEAD_BEEF) begin tests_failed++; $display("FAIL bypass_fwd: got %h expected %h", rd1, 64'hDEAD_BEEF); end
        tests_run++;
        if (nb_rd1 !== 64'd0) begin tests_failed++; $display("FAIL bypass_nb_old: got %h expected %h", nb_rd1, 64'd0); end
        tests_run++;
        if (rd2 !== 64'h394) begin tests_failed++; $display("FAIL bypass_other_port: got %h expected %h", rd2, 64'h394); end
        tick();
        idle_inputs();
        mid();
        tests_run++;
        if (rd1 !== 64'hDEAD_BEEF) begin tests_failed++; $display("FAIL bypass_after: got %h expected %h", rd1, 64'hDEAD_BEEF); end
        tests_run++;
        if (nb_rd1 !== 64'hDEAD_BEEF) begin tests_failed++; $display("FAIL bypass_nb_after: got %h expected %h", nb_rd1, 64'hDEAD_BEEF); end
        tick();
    endtask

    task automatic test_zero_reg();
        reg_write       = 1'b1;
        reg_write_dest  = 5'd31;
        reg_write_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        issue_valid     = 1'b1;
        issue_dest      = 5'd31;
        reg_read_addr_1 = 5'd31;
        reg_read_addr_2 = 5'd31;
        mid();
        tests_run++;
        if (rd1 !== 64'd0) begin tests_failed++; $display("FAIL zero_fwd_rd1: got %h expected %h", rd1, 64'd0); end
        tests_run++;
        if (rd2 !== 64'd0) begin tests_failed++; $display("FAIL zero_fwd_rd2: got %h expected %h", rd2, 64'd0); end
        tick();
        idle_inputs();
        mid();
        tests_run++;
        if (rd1 !== 64'd0) begin tests_failed++; $display("FAIL zero_rd1: got %h expected %h", rd1, 64'd0); end
        tests_run++;
        if (nb_rd2 !== 64'd0) begin tests_failed++; $display("FAIL zero_nb_rd2: got %h expected %h", nb_rd2, 64'd0); end
        tests_run++;
        if (busy1 !== 1'b0 || busy2 !== 1'b0) begin tests_failed++; $display("FAIL zero_busy: got %b%b expected 00", busy1, busy2); end
        tests_run++;
        if (nb_busy1 !== 1'b0) begin tests_failed++; $display("FAIL zero_nb_busy: got %b expected 0", nb_busy1); end
        tick();
    endtask

    task automatic test_scoreboard();
        issue_valid     = 1'b1;
        issue_dest      = 5'd9;
        reg_read_addr_1 = 5'd9;
        reg_read_addr_2 = 5'd3;
        tick();
        idle_inputs();
        mid();
        tests_run++;
        if (busy1 !== 1'b1) begin tests_failed++; $display("FAIL sb_busy_n1: got %b expected 1", busy1); end
        tests_run++;
        if (busy2 !== 1'b0) begin tests_failed++; $display("FAIL sb_busy2_other: got %b expected 0", busy2); end
        tick();
        mid();
        tests_run++;
        if (busy1 !== 1'b1) begin tests_failed++; $display("FAIL sb_busy_n2: got %b expected 1", busy1); end
        tick();
        reg_write      = 1'b1;
        reg_write_dest = 5'd9;
        reg_write_data = 64'h55;
        mid();
        tests_run++;
        if (busy1 !== 1'b0) begin tests_failed++; $display("FAIL sb_busy_wr: got %b expected 0", busy1); end
        tests_run++;
        if (rd1 !== 64'h55) begin tests_failed++; $display("FAIL sb_fwd_data: got %h expected %h", rd1, 64'h55); end
        tests_run++;
        if (nb_busy1 !== 1'b1) begin tests_failed++; $display("FAIL sb_nb_busy_wr: got %b expected 1", nb_busy1); end
        tick();
        idle_inputs();
        mid();
        tests_run++;
        if (busy1 !== 1'b0) begin tests_failed++; $display("FAIL sb_busy_after: got %b expected 0", busy1); end
        tests_run++;
        if (nb_busy1 !== 1'b0) begin tests_failed++; $display("FAIL sb_nb_busy_after: got %b expected 0", nb_busy1); end
        tests_run++;
        if (rd1 !== 64'h55) begin tests_failed++; $display("FAIL sb_data_after: got %h expected %h", rd1, 64'h55); end
        tick();
    endtask

    task automatic test_back_to_back();
        reg_write       = 1'b1;
        reg_write_dest  = 5'd1;
        reg_write_data  = 64'hA;
        reg_read_addr_1 = 5'd1;
        reg_read_addr_2 = 5'd1;
        tick();
        reg_write_data = 64'hB;
        mid();
        tests_run++;
        if (rd1 !== 64'hB) begin tests_failed++; $display("FAIL b2b_fwd_rd1: got %h expected %h", rd1, 64'hB); end
        tests_run++;
        if (nb_rd2 !== 64'hA) begin tests_failed++; $display("FAIL b2b_nb_rd2: got %h expected %h", nb_rd2, 64'hA); end
        tick();
        idle_inputs();
        mid();
        tests_run++;
        if (rd2 !== 64'hB) begin tests_failed++; $display("FAIL b2b_rd2: got %h expected %h", rd2, 64'hB); end
        tests_run++;
        if (nb_rd1 !== 64'hB) begin tests_failed++; $display("FAIL b2b_nb_rd1: got %h expected %h", nb_rd1, 64'hB); end
        tick();
    endtask

    task automatic test_issue_write_reset();
        issue_valid     = 1'b1;
        issue_dest      = 5'd4;
        reg_write       = 1'b1;
        reg_write_dest  = 5'd4;
        reg_write_data  = 64'd1;
        reg_read_addr_1 = 5'd4;
        reg_read_addr_2 = 5'd7;
        tick();
        idle_inputs();
        mid();
        tests_run++;
        if (busy1 !== 1'b1) begin tests_failed++; $display("FAIL iw_busy: got %b expected 1", busy1); end
        tests_run++;
        if (nb_busy1 !== 1'b1) begin tests_failed++; $display("FAIL iw_nb_busy: got %b expected 1", nb_busy1); end
        tests_run++;
        if (rd1 !== 64'd1) begin tests_failed++; $display("FAIL iw_data: got %h expected %h", rd1, 64'd1); end
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        mid();
        tests_run++;
        if (rd1 !== 64'd0) begin tests_failed++; $display("FAIL rst_mid_rd1: got %h expected %h", rd1, 64'd0); end
        tests_run++;
        if (busy1 !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy: got %b expected 0", busy1); end
        tests_run++;
        if (rd2 !== 64'd0) begin tests_failed++; $display("FAIL rst_mid_rd2: got %h expected %h", rd2, 64'd0); end
        tests_run++;
        if (nb_busy1 !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_nb_busy: got %b expected 0", nb_busy1); end
        tick();
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        reset           = 1'b1;
        reg_read_addr_1 = 5'd0;
        reg_read_addr_2 = 5'd0;
        idle_inputs();
        #1;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_back_to_back();
        test_issue_write_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
